// File: rtl/alu_op_b_stage_pkg.sv
// Shared definitions for the registered ALU operand-B stage.
//   - select-vector width and bit indices (highest set bit wins)
//   - FSM state encoding
//   - operand source enumeration and priority decode helper
package alu_op_b_stage_pkg;

  localparam int MUX_ALU_OP_B_SEL_WIDTH = 4;

  localparam int SEL_REG16    = 0;
  localparam int SEL_MEM_WORD = 1;
  localparam int SEL_MEM_SEXT = 2;
  localparam int SEL_CONST    = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_VALID    = 2'd2
  } op_b_state_e;

  typedef enum logic [2:0] {
    SRC_REG8,
    SRC_REG16,
    SRC_MEM_WORD,
    SRC_MEM_SEXT,
    SRC_CONST
  } op_b_src_e;

  // Several bits may be set at once; the highest one decides.
  function automatic op_b_src_e sel_decode(logic [MUX_ALU_OP_B_SEL_WIDTH-1:0] s);
    if (s[SEL_CONST])         return SRC_CONST;
    else if (s[SEL_MEM_SEXT]) return SRC_MEM_SEXT;
    else if (s[SEL_MEM_WORD]) return SRC_MEM_WORD;
    else if (s[SEL_REG16])    return SRC_REG16;
    else                      return SRC_REG8;
  endfunction

endpackage

// File: rtl/alu_op_b_byte_asm.sv
// Little-endian memory byte assembler for operand B.
//   clk, rst_n   : clock, async active-low reset
//   flush        : drop the partial word (count -> 0), incoming byte ignored
//   capture_clr  : operand consumed the buffer; restart, keeping a same-cycle
//                  byte as slot 0 of the next word
//   byte_in/_vld : incoming memory byte
//   count        : number of slots filled (0..BYTES)
//   word         : assembled word, slot k at bits [8k+7:8k]
module alu_op_b_byte_asm #(
  parameter int BYTES = 2,
  parameter int CW    = $clog2(BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               capture_clr,
  input  logic [7:0]         byte_in,
  input  logic               byte_vld,
  output logic [CW-1:0]      count,
  output logic [BYTES*8-1:0] word
);

  logic [BYTES-1:0][7:0] slot_q, slot_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (capture_clr) begin
      if (byte_vld) begin
        slot_d[0] = byte_in;
        count_d   = CW'(1);
      end else begin
        count_d = '0;
      end
    end else if (byte_vld && (count_q < CW'(BYTES))) begin
      // Bytes arriving on a full buffer are dropped.
      for (int k = 0; k < BYTES; k++)
        if (count_q == CW'(k)) slot_d[k] = byte_in;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign word  = slot_q;

endmodule

// File: rtl/alu_op_b_stage.sv
// Registered ALU operand-B selector with valid/ready output handshake.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : abort pending/held operand (op_b value kept)
//   sel                   : source select, highest set bit wins, 0 = reg8
//   load                  : capture request, ignored while busy
//   regfile_out_8bit_b    : 8-bit register port (zero-extended)
//   regfile_out_16bit_b   : W-bit register port
//   mem_byte/_valid       : memory data-in byte stream
//   op_b / op_b_valid     : registered operand and its valid flag
//   op_b_ready            : ALU consume strobe
//   busy                  : load is ignored this cycle
module alu_op_b_stage
  import alu_op_b_stage_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int unsigned CONST_VAL  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [MUX_ALU_OP_B_SEL_WIDTH-1:0] sel,
  input  logic                              load,
  input  logic [7:0]                        regfile_out_8bit_b,
  input  logic [DATA_WIDTH-1:0]             regfile_out_16bit_b,
  input  logic [7:0]                        mem_byte,
  input  logic                              mem_byte_valid,
  output logic [DATA_WIDTH-1:0]             op_b,
  output logic                              op_b_valid,
  input  logic                              op_b_ready,
  output logic                              busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  op_b_state_e                       state_q, state_d;
  logic [MUX_ALU_OP_B_SEL_WIDTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]             op_b_q, op_b_d;

  logic [CW-1:0]         byte_cnt;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [CW-1:0]         need;
  op_b_src_e             src;
  logic [DATA_WIDTH-1:0] cand;
  logic                  capture, cap_clr, accept;

  alu_op_b_byte_asm #(.BYTES(BYTES), .CW(CW)) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .capture_clr (cap_clr),
    .byte_in     (mem_byte),
    .byte_vld    (mem_byte_valid),
    .count       (byte_cnt),
    .word        (mem_word)
  );

  // In WAIT_MEM the operand is built from the select latched at load time.
  always_comb begin
    src = sel_decode((state_q == ST_WAIT_MEM) ? sel_q : sel);
    unique case (src)
      SRC_MEM_WORD: need = CW'(BYTES);
      SRC_MEM_SEXT: need = CW'(1);
      default:      need = '0;
    endcase
    unique case (src)
      SRC_CONST:    cand = DATA_WIDTH'(CONST_VAL);
      SRC_MEM_SEXT: cand = {{(DATA_WIDTH-8){mem_word[7]}}, mem_word[7:0]};
      SRC_MEM_WORD: cand = mem_word;
      SRC_REG16:    cand = regfile_out_16bit_b;
      default:      cand = {{(DATA_WIDTH-8){1'b0}}, regfile_out_8bit_b};
    endcase
  end

  // VALID with ready behaves like IDLE so back-to-back loads need no bubble.
  assign accept = (state_q == ST_IDLE) || ((state_q == ST_VALID) && op_b_ready);
  assign busy   = (state_q == ST_WAIT_MEM) || ((state_q == ST_VALID) && !op_b_ready);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_b_d  = op_b_q;
    capture = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_WAIT_MEM) begin
      if (byte_cnt >= need) capture = 1'b1;
    end else if (accept) begin
      if (load) begin
        if (byte_cnt >= need) begin
          capture = 1'b1;
        end else begin
          sel_d   = sel;
          state_d = ST_WAIT_MEM;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
    if (capture) begin
      op_b_d  = cand;
      state_d = ST_VALID;
    end
  end

  assign cap_clr = capture && (need != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_b_q  <= op_b_d;
    end
  end

  assign op_b       = op_b_q;
  assign op_b_valid = (state_q == ST_VALID);

endmodule

// File: tb/tb_alu_op_b_stage.sv
module tb_alu_op_b_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, load, mem_byte_valid, op_b_ready, busy, op_b_valid;
  logic [3:0]  sel;
  logic [7:0]  r8, mem_byte;
  logic [15:0] r16, op_b;

  logic        w_flush, w_load, w_mvld, w_ready, w_busy, w_valid;
  logic [3:0]  w_sel;
  logic [7:0]  w_mbyte;
  logic [31:0] w_r16, w_op_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_op_b_stage #(.DATA_WIDTH(16), .CONST_VAL(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .sel(sel), .load(load),
    .regfile_out_8bit_b(r8), .regfile_out_16bit_b(r16),
    .mem_byte(mem_byte), .mem_byte_valid(mem_byte_valid),
    .op_b(op_b), .op_b_valid(op_b_valid), .op_b_ready(op_b_ready), .busy(busy)
  );

  alu_op_b_stage #(.DATA_WIDTH(32), .CONST_VAL(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .sel(w_sel), .load(w_load),
    .regfile_out_8bit_b(8'h00), .regfile_out_16bit_b(w_r16),
    .mem_byte(w_mbyte), .mem_byte_valid(w_mvld),
    .op_b(w_op_b), .op_b_valid(w_valid), .op_b_ready(w_ready), .busy(w_busy)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  r8;
    logic [15:0] r16;
    int          nb;
    logic [7:0]  b0, b1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    mem_byte = b; mem_byte_valid = 1'b1;
    tick();
    mem_byte_valid = 1'b0;
  endtask

  task automatic send_byte32(input logic [7:0] b);
    w_mbyte = b; w_mvld = 1'b1;
    tick();
    w_mvld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //        sel      r8     r16       nb b0     b1     exp
    vecs[0] = '{4'b0000, 8'hA5, 16'h0000, 0, 8'h00, 8'h00, 16'h00A5};
    vecs[1] = '{4'b0001, 8'h00, 16'hBEEF, 0, 8'h00, 8'h00, 16'hBEEF};
    vecs[2] = '{4'b0011, 8'h00, 16'hBEEF, 2, 8'h34, 8'h12, 16'h1234};
    vecs[3] = '{4'b0100, 8'h00, 16'h0000, 1, 8'hF6, 8'h00, 16'hFFF6};
    vecs[4] = '{4'b0100, 8'h00, 16'h0000, 1, 8'h7F, 8'h00, 16'h007F};
    vecs[5] = '{4'b1111, 8'h00, 16'hBEEF, 2, 8'h01, 8'h02, 16'h0002};
    vecs[6] = '{4'b0110, 8'h00, 16'h0000, 1, 8'h80, 8'h00, 16'hFF80};
    vecs[7] = '{4'b0010, 8'h00, 16'h0000, 2, 8'hCD, 8'hAB, 16'hABCD};
    vecs[8] = '{4'b1000, 8'h77, 16'h5555, 0, 8'h00, 8'h00, 16'h0002};

    rst_n = 1'b0; flush = 0; load = 0; sel = 0; r8 = 0; r16 = 0;
    mem_byte = 0; mem_byte_valid = 0; op_b_ready = 0;
    w_flush = 0; w_load = 0; w_sel = 0; w_r16 = 0; w_mbyte = 0; w_mvld = 0; w_ready = 0;
    tick(); tick();
    check("reset_op_b", op_b, 0);
    check("reset_valid", op_b_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_count", dut.byte_cnt, 0);
    rst_n = 1'b1;
    tick();

    // reg8 capture, then hold with ready low; a load during hold is ignored
    sel = 4'b0000; r8 = 8'hA5; load = 1;
    tick();
    load = 0;
    check("reg8_op_b", op_b, 16'h00A5);
    check("reg8_valid", op_b_valid, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin sel = 4'b0001; r16 = 16'h9999; load = 1; end
      else load = 0;
      tick();
      check("hold_op_b", op_b, 16'h00A5);
      check("hold_busy", busy, 1);
    end
    load = 0; op_b_ready = 1;
    tick();
    op_b_ready = 0;
    check("release_valid", op_b_valid, 0);

    // mem word via WAIT_MEM
    sel = 4'b0010; load = 1;
    tick();
    load = 0; sel = 4'b0000;
    check("wait_busy", busy, 1);
    check("wait_valid", op_b_valid, 0);
    send_byte(8'h34);
    send_byte(8'h12);
    check("wait_not_yet", op_b_valid, 0);
    tick();
    check("memword_op_b", op_b, 16'h1234);
    check("memword_valid", op_b_valid, 1);
    check("memword_count", dut.byte_cnt, 0);
    op_b_ready = 1; tick(); op_b_ready = 0;

    // table-driven single-shot loads
    for (int v = 0; v < 9; v++) begin
      flush = 1; tick(); flush = 0;
      if (vecs[v].nb > 0) send_byte(vecs[v].b0);
      if (vecs[v].nb > 1) send_byte(vecs[v].b1);
      sel = vecs[v].sel; r8 = vecs[v].r8; r16 = vecs[v].r16; load = 1;
      tick();
      load = 0;
      check($sformatf("vec%0d_op_b", v), op_b, vecs[v].exp);
      check($sformatf("vec%0d_valid", v), op_b_valid, 1);
      op_b_ready = 1; tick(); op_b_ready = 0;
      check($sformatf("vec%0d_release", v), op_b_valid, 0);
    end
    flush = 1; tick(); flush = 0;

    // const then back-to-back reg16 without a bubble
    sel = 4'b1111; r16 = 16'hBEEF; load = 1;
    tick();
    check("b2b_const", op_b, 16'h0002);
    op_b_ready = 1; sel = 4'b0001;
    tick();
    check("b2b_reg16", op_b, 16'hBEEF);
    check("b2b_valid", op_b_valid, 1);
    load = 0;
    tick();
    op_b_ready = 0;
    check("b2b_release", op_b_valid, 0);

    // byte arriving in the sext capture cycle belongs to the next operand
    send_byte(8'hA0);
    sel = 4'b0100; load = 1; mem_byte = 8'h81; mem_byte_valid = 1;
    tick();
    mem_byte_valid = 0;
    check("cap_byte_op_b", op_b, 16'hFFA0);
    check("cap_byte_count", dut.byte_cnt, 1);
    op_b_ready = 1;
    tick();
    check("cap_byte_next", op_b, 16'hFF81);
    load = 0;
    tick();
    op_b_ready = 0;
    check("cap_byte_count0", dut.byte_cnt, 0);

    // flush in WAIT_MEM dominates a same-cycle byte, then drop-on-full
    sel = 4'b0010; load = 1;
    tick();
    load = 0;
    send_byte(8'h55);
    flush = 1; mem_byte = 8'h66; mem_byte_valid = 1;
    tick();
    flush = 0; mem_byte_valid = 0;
    check("flush_valid", op_b_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_count", dut.byte_cnt, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("full_count", dut.byte_cnt, 2);
    sel = 4'b0010; load = 1;
    tick();
    load = 0;
    check("drop_op_b", op_b, 16'h2211);
    op_b_ready = 1; tick(); op_b_ready = 0;

    // async reset in VALID, mid-cycle
    sel = 4'b0000; r8 = 8'h5A; load = 1;
    tick();
    load = 0;
    check("pre_rst_valid", op_b_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", op_b_valid, 0);
    check("async_rst_op_b", op_b, 0);
    rst_n = 1'b1;
    tick();

    // 32-bit instance
    send_byte32(8'h01);
    send_byte32(8'h02);
    send_byte32(8'h03);
    send_byte32(8'h04);
    w_sel = 4'b0010; w_load = 1;
    tick();
    w_load = 0;
    check("w32_word", w_op_b, 32'h04030201);
    check("w32_valid", w_valid, 1);
    w_ready = 1; tick(); w_ready = 0;
    send_byte32(8'h9C);
    w_sel = 4'b0100; w_load = 1;
    tick();
    w_load = 0;
    check("w32_sext", w_op_b, 32'hFFFFFF9C);
    w_ready = 1; tick(); w_ready = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_b_stage.md
Name: alu_op_b_stage

Overview:
Registered, parametrised successor of the ALU operand-B multiplexer.
- Selects operand B from one of five sources:
  - 8-bit register file port
  - W-bit register file port
  - memory word assembled from sequential bytes
  - sign-extended memory displacement
  - programmable constant
- Holds the result in an output register with a valid/ready handshake.
- Sits between the register file / memory-data-in path and the ALU.
- Lets the control FSM issue the operand request before multi-byte immediates (e.g. LD rr,nn / ADD IX,d) have fully arrived.

Parameters:
DATA_WIDTH, 16, operand width W; multiple of 8, at least 16
CONST_VAL, 2, value driven for the constant source, zero-extended to W
BYTES, DATA_WIDTH/8, derived, not overridable; memory bytes per word

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any pending or held operand
sel  in  4  one-hot-ish source select (bit0 reg16, bit1 mem word, bit2 mem lo sign-ext, bit3 const); all-zero selects reg8 zero-extended
load  in  1  request capture of operand per sel
regfile_out_8bit_b  in  8  8-bit register file read port B
regfile_out_16bit_b  in  W  wide register file read port B
mem_byte  in  8  memory data-in byte
mem_byte_valid  in  1  mem_byte valid this cycle
op_b  out  W  registered operand B
op_b_valid  out  1  op_b holds a valid operand
op_b_ready  in  1  ALU consumes op_b when op_b_valid and op_b_ready both high
busy  out  1  load is ignored this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; op_b = 0; op_b_valid = 0; byte count = 0
  - byte buffer = 0; latched sel = 0; busy = 0
- Select priority: highest set sel bit wins (bit3 > bit2 > bit1 > bit0 > default reg8). Multiple set bits are legal, not an error.
- Width rules:
  - reg8 source: zero-extended to W.
  - mem lo sign-ext: byte 0 replicated bit 7 into upper W-8 bits.
  - mem word: little-endian; byte k goes to bits [8k+7:8k].
  - CONST_VAL: truncated to W.
- Byte assembler:
  - count 0..BYTES; each mem_byte_valid writes slot[count] and increments count.
  - When count == BYTES, further bytes are dropped.
  - need = BYTES for mem word, 1 for sign-ext, 0 otherwise.
- FSM states: IDLE, WAIT_MEM, VALID.
  - IDLE, load=1:
    - If count >= need: capture next edge; go to VALID.
    - Else: latch sel; go to WAIT_MEM.
  - WAIT_MEM: when registered count >= need, capture using the latched sel; go to VALID. Minimum latency is one cycle after the final byte edge.
  - VALID: op_b_valid = 1 and op_b is stable until handshake.
    - On op_b_ready: with load=1, behave as IDLE+load in the same cycle (back-to-back, no bubble); otherwise go to IDLE.
- Capture:
  - Register op_b and set op_b_valid.
  - If need > 0, clear count to 0.
  - A mem_byte_valid in the capture cycle is written to slot 0 and count becomes 1; it belongs to the next operand.
- Latency: load in IDLE with data available -> op_b_valid high on the next edge (1 cycle).
- busy = (state == WAIT_MEM) or (state == VALID and not op_b_ready).
  - load while busy is ignored, with no state change.
  - The control FSM must not rely on it being queued.
- flush:
  - Dominates load, op_b_ready and mem_byte_valid in the same cycle.
  - Next state IDLE; op_b_valid = 0; count = 0.
  - op_b value is retained.
- Async reset mid-WAIT_MEM or mid-VALID: all state returns to reset values immediately; partial bytes are lost.
- op_b_ready while op_b_valid = 0 has no effect.

Decomposition:
- Shared package/header (alongside the existing bus-width header):
  - MUX_ALU_OP_B_SEL_WIDTH = 4
  - the four select-bit index constants
  - FSM state encodings (2 bits)
- One sub-module: alu_op_b_byte_asm. It holds the byte buffer, count, drop-on-full logic and clear/insert-slot-0 behaviour, and exposes count and the assembled word.
- The source-select priority logic stays combinational inside the top module.

Test Plan:
- Reset, then load with sel=0000 and regfile_out_8bit_b=8'hA5 -> next cycle op_b=16'h00A5, op_b_valid=1; hold op_b_ready=0 for 3 cycles -> op_b unchanged, busy=1.
- load with sel=0010 and no bytes -> WAIT_MEM; bytes 8'h34 then 8'h12 -> op_b=16'h1234 one cycle after the second byte edge; count returns to 0.
- sel=0100 with byte 8'hF6 already buffered, load -> op_b=16'hFFF6 in 1 cycle; repeat with 8'h7F -> 16'h007F.
- sel=1111 and regfile_out_16bit_b=16'hBEEF, load -> op_b=16'h0002. Then VALID with op_b_ready=1, load=1 and sel=0001 in the same cycle -> op_b=16'hBEEF on the next edge with no bubble.
- In WAIT_MEM after one byte, assert flush together with mem_byte_valid -> IDLE, op_b_valid=0, count=0. Then 3 bytes 11,22,33 arrive with no load -> the third is dropped; load sel=0010 -> op_b=16'h2211.
- Pulse rst_n low asynchronously in VALID mid-cycle -> op_b_valid and op_b drop to 0 before the next clk edge. Re-run with DATA_WIDTH=32, bytes 01,02,03,04 -> op_b=32'h04030201.
